hpm_counter_bank: RTL and testbench

// Parametrised hardware performance-monitor counter bank fed by the core trace event vector
// (cva5_trace_events_t, flattened). NUM_COUNTERS counters, each selecting one event by run-time config.

---
 rtl/hpm_counter_bank_pkg.sv | 33 +++
 rtl/hpm_counter_bank_if.sv | 27 ++
 rtl/hpm_counter_bank_counter.sv | 69 ++++++
 rtl/hpm_counter_bank.sv | 72 +++++++
 tb/tb_hpm_counter_bank.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hpm_counter_bank_pkg.sv
// Shared types for the performance-monitor counter bank: the flattened trace event
// vector, the selector config record and index-width helpers.
package hpm_types;

  // Packed struct: the last field is event bit 0, the first field is the MSB.
  typedef struct packed {
    logic store_op;
    logic load_op;
    logic branch_or_jump_op;
    logic alu_op;
    logic div_op;
    logic mul_op;
    logic no_instruction_stall;
    logic no_id_stall;
    logic operand_stall;
    logic unit_stall;
    logic other_stall;
    logic instruction_issued;
  } cva5_trace_events_t;

  localparam int HPM_NUM_TRACE_EVENTS = $bits(cva5_trace_events_t);
  localparam int HPM_ESEL_W           = $clog2(HPM_NUM_TRACE_EVENTS + 1);
  localparam int HPM_DATA_W           = 32;

  typedef struct packed {
    logic [HPM_ESEL_W-1:0] sel;
  } hpm_cfg_t;

  function automatic int hpm_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hpm_counter_bank_if.sv
// CSR-side access port of the counter bank: selector config, half-word write and
// registered half-word read.
interface hpm_counter_bank_if #(
  parameter int CIDX_W = 2,
  parameter int ESEL_W = 4
);
  logic              cfg_we;
  logic [CIDX_W-1:0] cfg_idx;
  logic [ESEL_W-1:0] cfg_sel;
  logic              wr_en;
  logic [CIDX_W-1:0] wr_idx;
  logic              wr_hi;
  logic [31:0]       wr_data;
  logic [CIDX_W-1:0] rd_idx;
  logic              rd_hi;
  logic [31:0]       rd_data;

  modport master (
    output cfg_we, cfg_idx, cfg_sel, wr_en, wr_idx, wr_hi, wr_data, rd_idx, rd_hi,
    input  rd_data
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_sel, wr_en, wr_idx, wr_hi, wr_data, rd_idx, rd_hi,
    output rd_data
  );
endinterface

// File: rtl/hpm_counter_bank_counter.sv
// One counter slice: event selector, increment, half-word write, wrap and sticky overflow.
module hpm_counter
  import hpm_types::*;
#(
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_EVENTS    = HPM_NUM_TRACE_EVENTS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_EVENTS-1:0]              events,
  input  logic                               freeze,
  input  logic                               inhibit,
  input  logic                               cfg_we,
  input  logic [$clog2(NUM_EVENTS+1)-1:0]    cfg_sel,
  input  logic                               wr_en,
  input  logic                               wr_hi,
  input  logic [31:0]                        wr_data,
  input  logic                               ovf_clr,
  output logic [COUNTER_WIDTH-1:0]           cnt,
  output logic                               ovf
);
  localparam int ESEL_W   = $clog2(NUM_EVENTS + 1);
  localparam int EV_PAD_W = 2 ** ESEL_W;

  logic [COUNTER_WIDTH-1:0] r_cnt;
  logic [COUNTER_WIDTH-1:0] w_cnt_next;
  logic [ESEL_W-1:0]        r_sel;
  logic                     r_ovf;
  logic [EV_PAD_W-1:0]      w_ev_pad;
  logic                     w_hit;
  logic                     w_inc;
  logic                     w_wrap;

  // Bit 0 stands for "off"; selectors past the last event land on zero padding.
  assign w_ev_pad = EV_PAD_W'({events, 1'b0});

  always_comb begin
    w_hit      = w_ev_pad[r_sel];
    w_inc      = w_hit & ~inhibit & ~freeze & ~wr_en;
    w_wrap     = w_inc & (&r_cnt);
    w_cnt_next = r_cnt;
    if (wr_en) begin
      if (wr_hi) begin
        w_cnt_next = COUNTER_WIDTH'({wr_data, r_cnt[31:0]});
      end else begin
        w_cnt_next = {r_cnt[COUNTER_WIDTH-1:32], wr_data};
      end
    end else if (w_inc) begin
      w_cnt_next = r_cnt + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sel <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_ovf <= w_wrap | (r_ovf & ~ovf_clr);
      if (cfg_we) begin
        r_sel <= cfg_sel;
      end
    end
  end

  assign cnt = r_cnt;
  assign ovf = r_ovf;
endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of performance counters; per-slice logic lives in hpm_counter, this level
// decodes CSR indices and owns the registered read port and interrupt.
module hpm_counter_bank
  import hpm_types::*;
#(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_EVENTS    = HPM_NUM_TRACE_EVENTS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_EVENTS-1:0]   events,
  input  logic                    freeze,
  input  logic [NUM_COUNTERS-1:0] inhibit,
  input  logic [NUM_COUNTERS-1:0] ovf_clr,
  output logic [NUM_COUNTERS-1:0] ovf,
  output logic                    ovf_irq,
  hpm_counter_bank_if.slave       csr
);
  localparam int CIDX_W = hpm_idx_w(NUM_COUNTERS);

  logic [COUNTER_WIDTH-1:0] w_cnt [NUM_COUNTERS];
  logic [31:0]              w_rd_word;
  logic [31:0]              r_rd_data;
  logic                     r_ovf_irq;

  generate
    for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_ctr
      hpm_counter #(
        .COUNTER_WIDTH(COUNTER_WIDTH),
        .NUM_EVENTS   (NUM_EVENTS)
      ) u_ctr (
        .clk    (clk),
        .rst    (rst),
        .events (events),
        .freeze (freeze),
        .inhibit(inhibit[gi]),
        .cfg_we (csr.cfg_we && (csr.cfg_idx == CIDX_W'(gi))),
        .cfg_sel(csr.cfg_sel),
        .wr_en  (csr.wr_en && (csr.wr_idx == CIDX_W'(gi))),
        .wr_hi  (csr.wr_hi),
        .wr_data(csr.wr_data),
        .ovf_clr(ovf_clr[gi]),
        .cnt    (w_cnt[gi]),
        .ovf    (ovf[gi])
      );
    end
  endgenerate

  // Indices with no matching counter fall through to the zero default.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (csr.rd_idx == CIDX_W'(i)) begin
        w_rd_word = csr.rd_hi ? 32'(w_cnt[i][COUNTER_WIDTH-1:32]) : w_cnt[i][31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
      r_ovf_irq <= 1'b0;
    end else begin
      r_rd_data <= w_rd_word;
      r_ovf_irq <= |ovf;
    end
  end

  assign csr.rd_data = r_rd_data;
  assign ovf_irq     = r_ovf_irq;
endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed and randomized checks of hpm_counter_bank against a cycle-level
// arithmetic model of the counters, selectors and overflow flags.
module tb_hpm_counter_bank;
  localparam int N  = 3;
  localparam int W  = 40;
  localparam int NE = 12;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

  logic          clk = 1'b0;
  logic          rst;
  logic [NE-1:0] events;
  logic          freeze;
  logic [N-1:0]  inhibit;
  logic [N-1:0]  ovf_clr;
  logic [N-1:0]  ovf;
  logic          ovf_irq;

  hpm_counter_bank_if #(.CIDX_W(2), .ESEL_W(4)) csr ();

  hpm_counter_bank #(
    .NUM_COUNTERS (N),
    .COUNTER_WIDTH(W),
    .NUM_EVENTS   (NE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .events (events),
    .freeze (freeze),
    .inhibit(inhibit),
    .ovf_clr(ovf_clr),
    .ovf    (ovf),
    .ovf_irq(ovf_irq),
    .csr    (csr.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  longint unsigned m_cnt [N];
  int              m_sel [N];
  logic [N-1:0]    m_ovf;
  logic            m_irq;
  logic [31:0]     m_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] rd_next;
    logic        irq_next;
    logic        hit;
    logic        wrap;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0;
        m_sel[i] = 0;
      end
      m_ovf = '0;
      m_irq = 1'b0;
      m_rd  = '0;
    end else begin
      rd_next = '0;
      if (int'(csr.rd_idx) < N)
        rd_next = csr.rd_hi ? 32'(m_cnt[csr.rd_idx] >> 32) : 32'(m_cnt[csr.rd_idx]);
      irq_next = |m_ovf;
      for (int i = 0; i < N; i++) begin
        hit  = 1'b0;
        wrap = 1'b0;
        if (m_sel[i] >= 1 && m_sel[i] <= NE) hit = events[m_sel[i]-1];
        if (csr.wr_en && int'(csr.wr_idx) == i) begin
          if (csr.wr_hi)
            m_cnt[i] = (m_cnt[i] & 64'hFFFF_FFFF) | ((64'(csr.wr_data) << 32) & MASK);
          else
            m_cnt[i] = (m_cnt[i] & ~64'hFFFF_FFFF) | 64'(csr.wr_data);
        end else if (hit && !inhibit[i] && !freeze) begin
          if (m_cnt[i] == MASK) begin
            m_cnt[i] = 0;
            wrap = 1'b1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        m_ovf[i] = wrap | (m_ovf[i] & ~ovf_clr[i]);
        if (csr.cfg_we && int'(csr.cfg_idx) == i) m_sel[i] = int'(csr.cfg_sel);
      end
      m_rd  = rd_next;
      m_irq = irq_next;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("ovf_irq", 64'(ovf_irq), 64'(m_irq));
    chk("rd_data", 64'(csr.rd_data), 64'(m_rd));
  endtask

  task automatic idle_ctl();
    csr.cfg_we = 1'b0;
    csr.wr_en  = 1'b0;
    ovf_clr    = '0;
  endtask

  task automatic do_write(input int idx, input logic hi, input logic [31:0] data);
    csr.wr_en   = 1'b1;
    csr.wr_idx  = 2'(idx);
    csr.wr_hi   = hi;
    csr.wr_data = data;
    step();
    csr.wr_en = 1'b0;
    $display("write idx=%0d hi=%0d data=%h", idx, hi, data);
  endtask

  task automatic do_cfg(input int idx, input int sel);
    csr.cfg_we  = 1'b1;
    csr.cfg_idx = 2'(idx);
    csr.cfg_sel = 4'(sel);
    step();
    csr.cfg_we = 1'b0;
    $display("cfg idx=%0d sel=%0d", idx, sel);
  endtask

  task automatic do_read(input int idx, input logic hi, input logic [31:0] exp, input string tag);
    csr.rd_idx = 2'(idx);
    csr.rd_hi  = hi;
    step();
    chk(tag, 64'(csr.rd_data), 64'(exp));
    $display("read idx=%0d hi=%0d data=%h", idx, hi, csr.rd_data);
  endtask

  initial begin
    rst = 1'b1; events = '0; freeze = 1'b0; inhibit = '0; ovf_clr = '0;
    csr.cfg_we = 1'b0; csr.cfg_idx = '0; csr.cfg_sel = '0;
    csr.wr_en = 1'b0; csr.wr_idx = '0; csr.wr_hi = 1'b0; csr.wr_data = '0;
    csr.rd_idx = '0; csr.rd_hi = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_rd", 64'(csr.rd_data), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    chk("reset_irq", 64'(ovf_irq), 64'd0);
    $display("reset done");

    // All events high but every selector off: nothing may count.
    events = '1;
    for (int k = 0; k < 10; k++) step();
    events = '0;
    for (int i = 0; i < N; i++) do_read(i, 1'b0, 32'd0, "sel_off_lo");
    chk("sel_off_ovf", 64'(ovf), 64'd0);

    do_cfg(0, 1);
    for (int k = 0; k < 5; k++) begin
      events = 12'h001; step();
      events = 12'h000; step();
    end
    do_read(0, 1'b0, 32'd5, "five_lo");
    do_read(0, 1'b1, 32'd0, "five_hi");

    do_write(1, 1'b1, 32'hFFFF_FFFF);
    do_write(1, 1'b0, 32'hFFFF_FFFE);
    do_cfg(1, 2);
    do_read(1, 1'b1, 32'h0000_00FF, "hi_trunc");
    events = 12'h002; step();
    step();
    events = 12'h000;
    chk("wrap_ovf", 64'(ovf), 64'h2);
    chk("wrap_irq_lag", 64'(ovf_irq), 64'd0);
    step();
    chk("wrap_irq", 64'(ovf_irq), 64'd1);
    do_read(1, 1'b0, 32'd0, "wrap_lo");
    do_read(1, 1'b1, 32'd0, "wrap_hi");

    do_write(1, 1'b1, 32'hFFFF_FFFF);
    do_write(1, 1'b0, 32'hFFFF_FFFF);
    events = 12'h002; ovf_clr = 3'b010; step();
    chk("set_beats_clr", 64'(ovf[1]), 64'd1);
    events = 12'h000; step();
    ovf_clr = '0;
    chk("clr_alone", 64'(ovf[1]), 64'd0);
    step();
    chk("irq_drop", 64'(ovf_irq), 64'd0);

    events = 12'h001;
    do_write(0, 1'b0, 32'd7);
    events = 12'h000;
    do_read(0, 1'b0, 32'd7, "write_prio");
    freeze = 1'b1; events = 12'h001;
    for (int k = 0; k < 3; k++) step();
    do_read(0, 1'b0, 32'd7, "freeze_hold");
    freeze = 1'b0; inhibit = 3'b001;
    for (int k = 0; k < 3; k++) step();
    do_read(0, 1'b0, 32'd7, "inhibit_hold");
    inhibit = '0; events = '0;

    do_read(N, 1'b0, 32'd0, "oob_rd_lo");
    do_read(N, 1'b1, 32'd0, "oob_rd_hi");
    do_write(N, 1'b0, 32'h1234_5678);
    do_read(0, 1'b0, 32'd7, "oob_wr_ignored");

    // Randomized traffic; writes favour near-wrap values so overflows occur.
    for (int k = 0; k < 400; k++) begin
      idle_ctl();
      rst         = ($urandom_range(0, 63) == 0);
      events      = NE'($urandom);
      freeze      = ($urandom_range(0, 9) == 0);
      inhibit     = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      ovf_clr     = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      csr.rd_idx  = 2'($urandom_range(0, 3));
      csr.rd_hi   = 1'($urandom);
      csr.cfg_we  = ($urandom_range(0, 7) == 0);
      csr.cfg_idx = 2'($urandom_range(0, 3));
      csr.cfg_sel = 4'($urandom_range(0, 15));
      csr.wr_en   = ($urandom_range(0, 7) == 0);
      csr.wr_idx  = 2'($urandom_range(0, 3));
      csr.wr_hi   = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       csr.wr_data = 32'hFFFF_FFFF;
        1:       csr.wr_data = 32'hFFFF_FFFC;
        default: csr.wr_data = $urandom;
      endcase
      step();
    end
    idle_ctl();
    rst = 1'b0;
    $display("random phase done");

    for (int i = 0; i < N; i++) do_cfg(i, i + 1);
    events = '1;
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1; step();
    rst = 1'b0;
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_rd", 64'(csr.rd_data), 64'd0);
    for (int i = 0; i < N; i++) do_read(i, 1'b0, 32'd0, "rst_cnt_sel");
    events = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
